// File: rtl/truth_table_sequencer_pkg.sv
// Shared definitions for the truth-table sequencer.
// Holds:
//   - the FSM state encoding
//   - the vector, table, counter and settle widths
//   - the golden truth table of F = (A+B)(C+D)E and its ones count
package truth_table_sequencer_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam int VEC_W       = 5;   // {A,B,C,D,E}
  localparam int TABLE_DEPTH = 32;  // 2**VEC_W vectors
  localparam int ONES_W      = 6;   // holds 0..32
  localparam int SETTLE_W    = 4;   // settle time 0..15

  // Bit i = F for vector i.  F is 1 only for odd vectors that have bit 1 or
  // bit 2 set and bit 3 or bit 4 set: vectors 11,13,15,19,21,23,27,29,31.
  localparam logic [TABLE_DEPTH-1:0] GOLDEN_TABLE = 32'hA8A8_A800;
  localparam int                     GOLDEN_ONES  = 9;

endpackage

// File: rtl/truth_table_sequencer_settle_timer.sv
// Loadable down-counter that times the settle wait for each vector.
// Ports:
//   clk        - rising-edge clock
//   rst        - asynchronous, active-high reset (count returns to 0)
//   load       - load load_value this cycle (has priority over dec)
//   load_value - value to load
//   dec        - decrement by one; the counter holds at zero
//   zero       - high when the count is zero
module truth_table_sequencer_settle_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_value;
    end else if (dec && (count_reg != '0)) begin
      count_reg <= count_reg - W'(1);
    end
  end

  assign zero = (count_reg == '0);

endmodule

// File: rtl/truth_table_sequencer.sv
// Self-test / characterisation driver for the 5-input gate block
// F = (A+B)(C+D)E.
//
// A sweep works as follows:
//   - All 32 input vectors are driven in order.
//   - Each vector is held for SETTLE+1 wait cycles and then sampled for one
//     cycle, so each vector costs SETTLE+2 cycles.
//   - F is captured into a truth table and its ones are counted.
//   - At the end, the captured table is compared with EXPECTED.
//
// Ports:
//   clk        - rising-edge clock
//   rst        - asynchronous, active-high reset
//   start      - one-cycle sweep request; only looked at in IDLE
//   abort      - cancel the sweep in any state (wins over start)
//   vec_out    - vector driven to the gate block, {A,B,C,D,E}
//   f_in       - F returned by the gate block
//   busy       - high while a sweep is in progress
//   done       - one-cycle pulse on normal sweep completion
//   table_out  - captured truth table, bit i = F for vector i
//   ones_count - number of ones captured so far
//   match      - table_out == EXPECTED, set when the sweep completes
module truth_table_sequencer
  import truth_table_sequencer_pkg::*;
#(
  parameter int unsigned              SETTLE   = 1,
  parameter logic [TABLE_DEPTH-1:0]   EXPECTED = GOLDEN_TABLE
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  output logic [VEC_W-1:0]       vec_out,
  input  logic                   f_in,
  output logic                   busy,
  output logic                   done,
  output logic [TABLE_DEPTH-1:0] table_out,
  output logic [ONES_W-1:0]      ones_count,
  output logic                   match
);

  localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE);
  localparam logic [VEC_W-1:0]    LAST_INDEX  = VEC_W'(TABLE_DEPTH - 1);

  state_t                   state_reg, state_next;
  logic [VEC_W-1:0]         index_reg, index_next;
  logic [VEC_W-1:0]         vec_next;
  logic                     busy_next, done_next, match_next;
  logic [TABLE_DEPTH-1:0]   table_next;
  logic [ONES_W-1:0]        ones_next;
  logic                     timer_load, timer_dec, timer_zero;

  truth_table_sequencer_settle_timer #(
    .W (SETTLE_W)
  ) u_settle_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (timer_load),
    .load_value (SETTLE_LOAD),
    .dec        (timer_dec),
    .zero       (timer_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= S_IDLE;
      index_reg  <= '0;
      vec_out    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      table_out  <= '0;
      ones_count <= '0;
      match      <= 1'b0;
    end else begin
      state_reg  <= state_next;
      index_reg  <= index_next;
      vec_out    <= vec_next;
      busy       <= busy_next;
      done       <= done_next;
      table_out  <= table_next;
      ones_count <= ones_next;
      match      <= match_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    index_next = index_reg;
    vec_next   = vec_out;
    busy_next  = busy;
    done_next  = 1'b0;     // done is a pulse; it only rises on the final sample
    table_next = table_out;
    ones_next  = ones_count;
    match_next = match;
    timer_load = 1'b0;
    timer_dec  = 1'b0;

    unique case (state_reg)
      S_IDLE: begin
        if (start && !abort) begin
          state_next = S_WAIT;
          index_next = '0;
          vec_next   = '0;
          busy_next  = 1'b1;
          table_next = '0;
          ones_next  = '0;
          match_next = 1'b0;
          timer_load = 1'b1;
        end
      end

      S_WAIT: begin
        if (abort) begin
          state_next = S_IDLE;
          busy_next  = 1'b0;
          vec_next   = '0;
        end else if (timer_zero) begin
          state_next = S_SAMPLE;
        end else begin
          timer_dec = 1'b1;
        end
      end

      S_SAMPLE: begin
        // An abort here drops this vector's capture entirely.
        if (abort) begin
          state_next = S_IDLE;
          busy_next  = 1'b0;
          vec_next   = '0;
        end else begin
          table_next[index_reg] = f_in;
          ones_next             = ones_count + ONES_W'(f_in);
          if (index_reg == LAST_INDEX) begin
            // done/busy become visible during the DONE cycle itself.
            state_next = S_DONE;
            busy_next  = 1'b0;
            done_next  = 1'b1;
          end else begin
            state_next = S_WAIT;
            index_next = index_reg + VEC_W'(1);
            vec_next   = index_reg + VEC_W'(1);
            timer_load = 1'b1;
          end
        end
      end

      S_DONE: begin
        state_next = S_IDLE;
        if (abort) begin
          // match stays at the 0 it was given when the sweep started.
          vec_next = '0;
        end else begin
          match_next = (table_out == EXPECTED);
        end
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

endmodule
